// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame master: command codes, frame geometry
// and the master state encoding.
package spi_pkg;

  // Command field, cmd_word[9:8]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Frame geometry
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned RD_BITS    = 8;
  localparam int unsigned PRE_CYCLES = 2;

  // Master state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PRE   = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_RECV  = 3'd4;
  localparam state_t ST_GAP   = 3'd5;

endpackage

// File: rtl/spi_frame_master.sv
// SPI frame master: sends a 10-bit command frame MSB-first on MOSI, one bit
// per clk, and for RD_DATA frames waits READ_WAIT cycles then captures a byte
// from MISO.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        frame request, sampled only while busy=0
//   cmd_word     [9:8] command, [7:0] address/data; sampled at acceptance
//   busy         high from the cycle after acceptance until the gap ends
//   done         one-cycle pulse at frame end
//   rd_data      last byte captured on an RD_DATA frame
//   rd_valid     one-cycle pulse with done on RD_DATA frames
//   SS_n, MOSI   slave select (active low) and serial data out
//   MISO         serial data in
module spi_frame_master #(
  parameter int unsigned READ_WAIT = 2,
  parameter int unsigned IDLE_GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  import spi_pkg::*;

  // Counter reload values; the counter runs N-1 down to 0 in an N-cycle state.
  localparam logic [3:0] PreLoad   = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] ShiftLoad = 4'(FRAME_BITS - 1);
  localparam logic [3:0] WaitLoad  = 4'(READ_WAIT - 1);
  localparam logic [3:0] RecvLoad  = 4'(RD_BITS - 1);
  localparam logic [3:0] GapLoad   = 4'(IDLE_GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] word_q, word_d;
  logic       is_read_q, is_read_d;
  logic [7:0] rd_sh_q, rd_sh_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       done_q, done_d;
  logic       rd_valid_q, rd_valid_d;
  logic       busy_q, busy_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       cnt_zero;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    is_read_d  = is_read_q;
    rd_sh_d    = rd_sh_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    cnt_zero   = (cnt_q == 4'd0);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          word_d    = cmd_word;
          is_read_d = (cmd_word[9:8] == CMD_RD_DATA);
          state_d   = ST_PRE;
          cnt_d     = PreLoad;
        end
      end
      ST_PRE: begin
        if (cnt_zero) begin
          state_d = ST_SHIFT;
          cnt_d   = ShiftLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
          if (is_read_q) begin
            state_d = ST_WAIT;
            cnt_d   = WaitLoad;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GapLoad;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          // MOSI always shows word[9]; shift only while bits remain
          word_d = {word_q[8:0], 1'b0};
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_RECV;
          cnt_d   = RecvLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECV: begin
        rd_sh_d = {rd_sh_q[6:0], MISO};
        if (cnt_zero) begin
          state_d    = ST_GAP;
          cnt_d      = GapLoad;
          rd_data_d  = {rd_sh_q[6:0], MISO};
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    mosi_d = ((state_d == ST_PRE) || (state_d == ST_SHIFT)) && word_d[9];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      word_q     <= 10'd0;
      is_read_q  <= 1'b0;
      rd_sh_q    <= 8'h00;
      rd_data_q  <= 8'h00;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      is_read_q  <= is_read_d;
      rd_sh_q    <= rd_sh_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;

endmodule
